uart_hex_capture: RTL and testbench

- Upstream feeder for the 6-digit 7-segment driver.
- Captures bytes from the UART receiver's one-cycle valid strobe and keeps the most recent received data as six hex nibbles, hex5 (oldest) down to hex0 (newest).
- Also provides an accepted-byte counter and an idle/stale flag for status LEDs.
- All outputs are registered, so the display driver sees only stable values.

---
 rtl/uart_hex_pkg.sv | 44 ++++
 rtl/uart_hex_capture_idle_timer.sv | 59 +++++
 rtl/uart_hex_capture.sv | 94 +++++++++
 tb/tb_uart_hex_capture.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_hex_pkg.sv
// uart_hex_pkg: shared constants and the ASCII-to-nibble decoder for the
// UART hex capture block. The decoder is only used when the block is built
// with UART_HEX_CAPTURE_ASCII_EN defined (terminal mode).
package uart_hex_pkg;

    localparam int DIGITS = 6;
    localparam int NIB_W  = 4;
    localparam int HEX_W  = DIGITS * NIB_W;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_UA  = 8'h41;
    localparam logic [7:0] CH_UF  = 8'h46;
    localparam logic [7:0] CH_LA  = 8'h61;
    localparam logic [7:0] CH_LF  = 8'h66;
    localparam logic [7:0] CH_ESC = 8'h1B;

    typedef struct packed {
        logic             valid;
        logic [NIB_W-1:0] nib;
    } hex_dec_t;

    // Map an ASCII character to {valid, nibble}; non-hex characters give valid=0.
    function automatic hex_dec_t ascii_to_nib(input logic [7:0] ch);
        hex_dec_t   res;
        logic [7:0] tmp;
        res = '{valid: 1'b0, nib: 4'h0};
        tmp = 8'h00;
        if (ch >= CH_0 && ch <= CH_9) begin
            tmp   = ch - CH_0;
            res   = '{valid: 1'b1, nib: tmp[3:0]};
        end else if (ch >= CH_UA && ch <= CH_UF) begin
            tmp   = ch - CH_UA + 8'd10;
            res   = '{valid: 1'b1, nib: tmp[3:0]};
        end else if (ch >= CH_LA && ch <= CH_LF) begin
            tmp   = ch - CH_LA + 8'd10;
            res   = '{valid: 1'b1, nib: tmp[3:0]};
        end else begin
            res   = '{valid: 1'b0, nib: 4'h0};
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_hex_capture_idle_timer.sv
// idle_timer: saturating inactivity counter with a registered stale flag.
// restart clears the counter and the flag; clr clears the counter but sets
// the flag (nothing seen since the clear). Reset leaves stale high.
module idle_timer #(
    parameter int IDLE_CYCLES = 60_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic clr,
    output logic stale
);

    localparam int            CW   = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] PRE  = CW'(IDLE_CYCLES - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stale_q;
    logic          stale_d;

    // Next-state: clr beats restart; otherwise count up and saturate at LAST.
    always_comb begin
        cnt_d   = cnt_q;
        stale_d = stale_q;
        if (clr) begin
            cnt_d   = '0;
            stale_d = 1'b1;
        end else if (restart) begin
            cnt_d   = '0;
            stale_d = 1'b0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == PRE) begin
                stale_d = 1'b1;
            end else begin
                stale_d = stale_q;
            end
        end else begin
            cnt_d   = cnt_q;
            stale_d = 1'b1;
        end
    end

    // Counter and flag registers; stale powers up high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            stale_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end

    assign stale = stale_q;

endmodule

// File: rtl/uart_hex_capture.sv
// uart_hex_capture: keeps the most recent UART bytes as six hex nibbles for
// the 7-segment driver, plus an accepted-byte counter and a stale flag.
// Build option UART_HEX_CAPTURE_ASCII_EN: bytes are decoded as ASCII hex
// characters (one nibble per accept, ESC acts as clear). Without it, each
// byte shifts in as two raw nibbles. All outputs come straight from flops.
module uart_hex_capture
    import uart_hex_pkg::*;
#(
    parameter int IDLE_CYCLES = 60_000_000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             freeze,
    input  logic             clr,
    output logic [3:0]       hex0,
    output logic [3:0]       hex1,
    output logic [3:0]       hex2,
    output logic [3:0]       hex3,
    output logic [3:0]       hex4,
    output logic [3:0]       hex5,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             stale
);

    logic [HEX_W-1:0] hex_q;
    logic [HEX_W-1:0] hex_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_s;
    logic             clr_s;
    logic [HEX_W-1:0] shift_s;
`ifdef UART_HEX_CAPTURE_ASCII_EN
    hex_dec_t         dec_s;
`endif

    // Accept/clear decode and next display/counter values.
    always_comb begin
        hex_d    = hex_q;
        cnt_d    = cnt_q;
`ifdef UART_HEX_CAPTURE_ASCII_EN
        dec_s    = ascii_to_nib(rx_data);
        clr_s    = clr | (rx_valid & ~freeze & (rx_data == CH_ESC));
        accept_s = rx_valid & ~freeze & ~clr & dec_s.valid;
        shift_s  = {hex_q[HEX_W-NIB_W-1:0], dec_s.nib};
`else
        clr_s    = clr;
        accept_s = rx_valid & ~freeze & ~clr;
        shift_s  = {hex_q[HEX_W-9:0], rx_data};
`endif
        if (clr_s) begin
            hex_d = '0;
            cnt_d = '0;
        end else if (accept_s) begin
            hex_d = shift_s;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            hex_d = hex_q;
            cnt_d = cnt_q;
        end
    end

    // Display shift register and accepted-byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_q <= '0;
            cnt_q <= '0;
        end else begin
            hex_q <= hex_d;
            cnt_q <= cnt_d;
        end
    end

    idle_timer #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (accept_s),
        .clr     (clr_s),
        .stale   (stale)
    );

    assign hex0     = hex_q[3:0];
    assign hex1     = hex_q[7:4];
    assign hex2     = hex_q[11:8];
    assign hex3     = hex_q[15:12];
    assign hex4     = hex_q[19:16];
    assign hex5     = hex_q[23:20];
    assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_uart_hex_capture.sv
// Directed bench for uart_hex_capture with IDLE_CYCLES=16. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_uart_hex_capture;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       freeze;
    logic       clr;
    logic [3:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [7:0] byte_cnt;
    logic       stale;

    int n_vec;
    int n_err;

    uart_hex_capture #(
        .IDLE_CYCLES (16),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .freeze   (freeze),
        .clr      (clr),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .byte_cnt (byte_cnt),
        .stale    (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] disp();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [23:0] h, input logic [7:0] c, input logic s);
        check_vec({tag, "_hex"}, 32'(disp()), 32'(h));
        check_vec({tag, "_cnt"}, 32'(byte_cnt), 32'(c));
        check_vec({tag, "_stale"}, 32'(stale), 32'(s));
    endtask

    // One-cycle strobe; returns on the falling edge after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        freeze   = 1'b0;
        clr      = 1'b0;
        #23;
        check_all("reset", 24'h000000, 8'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_all("idle100", 24'h000000, 8'd0, 1'b1);

`ifdef UART_HEX_CAPTURE_ASCII_EN
        send_byte(8'h31);
        send_byte(8'h61);
        check_all("asc_1a", 24'h00001A, 8'd2, 1'b0);
        send_byte(8'h5A);
        check_all("asc_Z", 24'h00001A, 8'd2, 1'b0);
        send_byte(8'h1B);
        check_all("asc_esc", 24'h000000, 8'd0, 1'b1);
        send_byte(8'h46);
        check_all("asc_F", 24'h00000F, 8'd1, 1'b0);
`else
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        check_all("three", 24'h123456, 8'd3, 1'b0);
        send_byte(8'hAB);
        check_all("fourth", 24'h3456AB, 8'd4, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
        end
        check_all("wrap", 24'hFDFEFF, 8'd4, 1'b0);

        // Frozen byte is dropped.
        freeze = 1'b1;
        send_byte(8'hFF);
        check_all("frz", 24'hFDFEFF, 8'd4, 1'b0);
        freeze = 1'b0;
        send_byte(8'h01);
        check_all("unfrz", 24'hFEFF01, 8'd5, 1'b0);

        // Strobes under freeze do not restart the timer.
        freeze = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h5A);
        end
        check_all("frz_tmr", 24'hFEFF01, 8'd5, 1'b1);
        freeze = 1'b0;

        // clr beats a simultaneous strobe; next byte accepted normally.
        clr      = 1'b1;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_all("clr", 24'h000000, 8'd0, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
        check_all("post_clr", 24'h000077, 8'd1, 1'b0);

        // clr still acts while frozen.
        freeze = 1'b1;
        clr    = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
        freeze = 1'b0;
        check_all("clr_frz", 24'h000000, 8'd0, 1'b1);

        // Stale threshold.
        send_byte(8'h9C);
        check_all("tmr0", 24'h00009C, 8'd1, 1'b0);
        repeat (14) @(negedge clk);
        check_vec("idle14_stale", 32'(stale), 32'd0);
        @(negedge clk);
        check_vec("idle15_stale", 32'(stale), 32'd1);
        repeat (30) @(negedge clk);
        check_vec("idle_sat_stale", 32'(stale), 32'd1);

        // Async reset mid-cycle.
        send_byte(8'h5A);
        check_all("pre_rst", 24'h009C5A, 8'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 24'h000000, 8'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
